// File: rtl/writeback_tracker_pkg.sv
// Shared types and constants for the EXE/MEM/WB destination tracker.
// Holds the forwarding-select encoding and the per-stage entry record.
package writeback_tracker_pkg;

  localparam int REG_ADDR_W = 4;
  localparam int NUM_REGS   = 16;

  localparam logic [1:0] FWD_REGFILE = 2'b00;
  localparam logic [1:0] FWD_MEM     = 2'b01;
  localparam logic [1:0] FWD_WB      = 2'b10;

  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] dest;
    logic                  wb_en;
    logic                  load;
    logic [REG_ADDR_W-1:0] src1;
    logic [REG_ADDR_W-1:0] src2;
    logic                  src2_valid;
  } stage_t;

  localparam stage_t BUBBLE = '0;

endpackage

// File: rtl/writeback_tracker_fwd_select.sv
// Operand forwarding select for one EXE source: MEM result beats WB result,
// and a load still sitting in MEM is never a forwarding source.
module fwd_select
  import writeback_tracker_pkg::*;
(
  input  logic                  fu_en_i,
  input  logic                  src_vld_i,
  input  logic [REG_ADDR_W-1:0] src_i,
  input  logic                  mem_valid_i,
  input  logic                  mem_wb_en_i,
  input  logic                  mem_load_i,
  input  logic [REG_ADDR_W-1:0] mem_dest_i,
  input  logic                  wb_valid_i,
  input  logic                  wb_wb_en_i,
  input  logic [REG_ADDR_W-1:0] wb_dest_i,
  output logic [1:0]            sel_o
);

  always_comb begin
    sel_o = FWD_REGFILE;
    if (fu_en_i && src_vld_i) begin
      if (mem_valid_i && mem_wb_en_i && !mem_load_i && (mem_dest_i == src_i)) begin
        sel_o = FWD_MEM;
      end else if (wb_valid_i && wb_wb_en_i && (wb_dest_i == src_i)) begin
        sel_o = FWD_WB;
      end
    end
  end

endmodule

// File: rtl/writeback_tracker.sv
// Tracks destination/write-enable/load info through EXE -> MEM -> WB with
// bubble, flush and freeze handling; produces forwarding selects and a pending mask.
module writeback_tracker
  import writeback_tracker_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_dest,
  input  logic                  id_wb_en,
  input  logic                  id_mem_r_en,
  input  logic [REG_ADDR_W-1:0] id_src1,
  input  logic [REG_ADDR_W-1:0] id_src2,
  input  logic                  id_src2_valid,
  input  logic                  hazard_detected,
  input  logic                  flush,
  input  logic                  freeze,
  input  logic                  fu_en,
  output logic [REG_ADDR_W-1:0] exe_dest,
  output logic                  exe_wb_en,
  output logic                  mem_r_en_exe,
  output logic [REG_ADDR_W-1:0] mem_dest,
  output logic                  mem_wb_en,
  output logic [REG_ADDR_W-1:0] wb_dest,
  output logic                  wb_en,
  output logic [1:0]            sel_src1,
  output logic [1:0]            sel_src2,
  output logic [NUM_REGS-1:0]   pending
);

  stage_t exe_q, exe_d;
  stage_t mem_q, mem_d;
  stage_t wb_q,  wb_d;
  stage_t id_entry;

  function automatic logic writes_reg(input stage_t s, input int r);
    return s.valid && s.wb_en && (s.dest == REG_ADDR_W'(r));
  endfunction

  always_comb begin
    id_entry            = BUBBLE;
    id_entry.valid      = 1'b1;
    id_entry.dest       = id_dest;
    id_entry.wb_en      = id_wb_en;
    id_entry.load       = id_mem_r_en;
    id_entry.src1       = id_src1;
    id_entry.src2       = id_src2;
    id_entry.src2_valid = id_src2_valid;
  end

  // Freeze outranks hazard/flush: the whole pipe holds and upstream re-presents.
  always_comb begin
    exe_d = exe_q;
    mem_d = mem_q;
    wb_d  = wb_q;
    if (!freeze) begin
      wb_d  = mem_q;
      mem_d = exe_q;
      if (flush || hazard_detected || !id_valid) begin
        exe_d = BUBBLE;
      end else begin
        exe_d = id_entry;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      exe_q <= BUBBLE;
      mem_q <= BUBBLE;
      wb_q  <= BUBBLE;
    end else begin
      exe_q <= exe_d;
      mem_q <= mem_d;
      wb_q  <= wb_d;
    end
  end

  assign exe_dest     = exe_q.dest;
  assign exe_wb_en    = exe_q.valid && exe_q.wb_en;
  assign mem_r_en_exe = exe_q.valid && exe_q.load;
  assign mem_dest     = mem_q.dest;
  assign mem_wb_en    = mem_q.valid && mem_q.wb_en;
  assign wb_dest      = wb_q.dest;
  assign wb_en        = wb_q.valid && wb_q.wb_en;

  always_comb begin
    pending = '0;
    for (int r = 0; r < NUM_REGS; r++) begin
      pending[r] = writes_reg(exe_q, r) || writes_reg(mem_q, r) || writes_reg(wb_q, r);
    end
  end

  fwd_select u_fwd_src1 (
    .fu_en_i     (fu_en),
    .src_vld_i   (exe_q.valid),
    .src_i       (exe_q.src1),
    .mem_valid_i (mem_q.valid),
    .mem_wb_en_i (mem_q.wb_en),
    .mem_load_i  (mem_q.load),
    .mem_dest_i  (mem_q.dest),
    .wb_valid_i  (wb_q.valid),
    .wb_wb_en_i  (wb_q.wb_en),
    .wb_dest_i   (wb_q.dest),
    .sel_o       (sel_src1)
  );

  fwd_select u_fwd_src2 (
    .fu_en_i     (fu_en),
    .src_vld_i   (exe_q.valid && exe_q.src2_valid),
    .src_i       (exe_q.src2),
    .mem_valid_i (mem_q.valid),
    .mem_wb_en_i (mem_q.wb_en),
    .mem_load_i  (mem_q.load),
    .mem_dest_i  (mem_q.dest),
    .wb_valid_i  (wb_q.valid),
    .wb_wb_en_i  (wb_q.wb_en),
    .wb_dest_i   (wb_q.dest),
    .sel_o       (sel_src2)
  );

  // WB retires next edge; its load/source fields have no consumer.
  logic unused_wb_fields;
  assign unused_wb_fields = ^{wb_q.load, wb_q.src1, wb_q.src2, wb_q.src2_valid};

endmodule

// File: tb/tb_writeback_tracker.sv
// Directed table-driven bench for writeback_tracker plus an asynchronous
// reset sequence; expected values are hand-computed per row.
module tb_writeback_tracker;

  logic       clk;
  logic       rst;
  logic       id_valid;
  logic [3:0] id_dest;
  logic       id_wb_en;
  logic       id_mem_r_en;
  logic [3:0] id_src1;
  logic [3:0] id_src2;
  logic       id_src2_valid;
  logic       hazard_detected;
  logic       flush;
  logic       freeze;
  logic       fu_en;
  logic [3:0] exe_dest;
  logic       exe_wb_en;
  logic       mem_r_en_exe;
  logic [3:0] mem_dest;
  logic       mem_wb_en;
  logic [3:0] wb_dest;
  logic       wb_en;
  logic [1:0] sel_src1;
  logic [1:0] sel_src2;
  logic [15:0] pending;

  writeback_tracker dut (
    .clk             (clk),
    .rst             (rst),
    .id_valid        (id_valid),
    .id_dest         (id_dest),
    .id_wb_en        (id_wb_en),
    .id_mem_r_en     (id_mem_r_en),
    .id_src1         (id_src1),
    .id_src2         (id_src2),
    .id_src2_valid   (id_src2_valid),
    .hazard_detected (hazard_detected),
    .flush           (flush),
    .freeze          (freeze),
    .fu_en           (fu_en),
    .exe_dest        (exe_dest),
    .exe_wb_en       (exe_wb_en),
    .mem_r_en_exe    (mem_r_en_exe),
    .mem_dest        (mem_dest),
    .mem_wb_en       (mem_wb_en),
    .wb_dest         (wb_dest),
    .wb_en           (wb_en),
    .sel_src1        (sel_src1),
    .sel_src2        (sel_src2),
    .pending         (pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int iv, idst, iwb, ild, s1, s2, s2v, hz, fl, fz, fu;
    int ed, ew, el, md, mw, wd, ww, sel1, sel2, pend;
  } vec_t;

  localparam int NV = 45;
  vec_t vecs [NV];

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input int row, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s row %0d: got 0x%0h expected 0x%0h", name, row, act, exp);
    end
  endtask

  task automatic drive(input int iv, input int idst, input int iwb, input int ild,
                       input int s1, input int s2, input int s2v, input int hz,
                       input int fl, input int fz, input int fu);
    id_valid        = iv[0];
    id_dest         = 4'(idst);
    id_wb_en        = iwb[0];
    id_mem_r_en     = ild[0];
    id_src1         = 4'(s1);
    id_src2         = 4'(s2);
    id_src2_valid   = s2v[0];
    hazard_detected = hz[0];
    flush           = fl[0];
    freeze          = fz[0];
    fu_en           = fu[0];
  endtask

  task automatic check_all(input int row, input vec_t v);
    check("exe_dest",     row, int'(exe_dest),     v.ed);
    check("exe_wb_en",    row, int'(exe_wb_en),    v.ew);
    check("mem_r_en_exe", row, int'(mem_r_en_exe), v.el);
    check("mem_dest",     row, int'(mem_dest),     v.md);
    check("mem_wb_en",    row, int'(mem_wb_en),    v.mw);
    check("wb_dest",      row, int'(wb_dest),      v.wd);
    check("wb_en",        row, int'(wb_en),        v.ww);
    check("sel_src1",     row, int'(sel_src1),     v.sel1);
    check("sel_src2",     row, int'(sel_src2),     v.sel2);
    check("pending",      row, int'(pending),      v.pend);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t z;
    //          iv idst iwb ild s1 s2 s2v hz fl fz fu | ed ew el md mw wd ww s1 s2 pend
    // ALU dependency chain, MEM then WB forwarding, src2_valid gating
    vecs[0]  = '{1, 3, 1, 0, 0, 0, 0, 0, 0, 0, 1,  3, 1, 0, 0, 0, 0, 0, 0, 0, 'h008};
    vecs[1]  = '{1, 4, 1, 0, 3, 0, 0, 0, 0, 0, 1,  4, 1, 0, 3, 1, 0, 0, 1, 0, 'h018};
    vecs[2]  = '{1, 6, 1, 0, 0, 3, 1, 0, 0, 0, 1,  6, 1, 0, 4, 1, 3, 1, 0, 2, 'h058};
    vecs[3]  = '{1, 8, 1, 0, 0, 4, 0, 0, 0, 0, 1,  8, 1, 0, 6, 1, 4, 1, 0, 0, 'h150};
    vecs[4]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1,  0, 0, 0, 8, 1, 6, 1, 0, 0, 'h140};
    vecs[5]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1,  0, 0, 0, 0, 0, 8, 1, 0, 0, 'h100};
    vecs[6]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1,  0, 0, 0, 0, 0, 0, 0, 0, 0, 'h000};
    // load-use with one-cycle hazard, then a load in MEM is not forwarded
    vecs[7]  = '{1, 5, 1, 1, 0, 0, 0, 0, 0, 0, 1,  5, 1, 1, 0, 0, 0, 0, 0, 0, 'h020};
    vecs[8]  = '{1, 9, 1, 0, 5, 0, 0, 1, 0, 0, 1,  0, 0, 0, 5, 1, 0, 0, 0, 0, 'h020};
    vecs[9]  = '{1, 9, 1, 0, 5, 0, 0, 0, 0, 0, 1,  9, 1, 0, 0, 0, 5, 1, 2, 0, 'h220};
    vecs[10] = '{1, 2, 1, 1, 0, 0, 0, 0, 0, 0, 1,  2, 1, 1, 9, 1, 0, 0, 0, 0, 'h204};
    vecs[11] = '{1,11, 1, 0, 2, 0, 0, 0, 0, 0, 1, 11, 1, 0, 2, 1, 9, 1, 0, 0, 'hA04};
    vecs[12] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1,  0, 0, 0,11, 1, 2, 1, 0, 0, 'h804};
    vecs[13] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1,  0, 0, 0, 0, 0,11, 1, 0, 0, 'h800};
    vecs[14] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1,  0, 0, 0, 0, 0, 0, 0, 0, 0, 'h000};
    // flush and hazard together: a single bubble
    vecs[15] = '{1,12, 1, 0, 0, 0, 0, 0, 0, 0, 1, 12, 1, 0, 0, 0, 0, 0, 0, 0, 'h1000};
    vecs[16] = '{1, 7, 1, 0, 0, 0, 0, 1, 1, 0, 1,  0, 0, 0,12, 1, 0, 0, 0, 0, 'h1000};
    vecs[17] = '{1,13, 1, 0, 0, 0, 0, 0, 0, 0, 1, 13, 1, 0, 0, 0,12, 1, 0, 0, 'h3000};
    vecs[18] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1,  0, 0, 0,13, 1, 0, 0, 0, 0, 'h2000};
    vecs[19] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1,  0, 0, 0, 0, 0,13, 1, 0, 0, 'h2000};
    vecs[20] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1,  0, 0, 0, 0, 0, 0, 0, 0, 0, 'h000};
    // freeze with dest 1/2/4 in EXE/MEM/WB, hazard/flush ignored meanwhile
    vecs[21] = '{1, 4, 1, 0, 0, 0, 0, 0, 0, 0, 1,  4, 1, 0, 0, 0, 0, 0, 0, 0, 'h010};
    vecs[22] = '{1, 2, 1, 0, 0, 0, 0, 0, 0, 0, 1,  2, 1, 0, 4, 1, 0, 0, 0, 0, 'h014};
    vecs[23] = '{1, 1, 1, 0, 2, 0, 0, 0, 0, 0, 1,  1, 1, 0, 2, 1, 4, 1, 1, 0, 'h016};
    vecs[24] = '{1, 9, 1, 0, 0, 0, 0, 0, 0, 1, 1,  1, 1, 0, 2, 1, 4, 1, 1, 0, 'h016};
    vecs[25] = '{1, 9, 1, 0, 0, 0, 0, 1, 1, 1, 1,  1, 1, 0, 2, 1, 4, 1, 1, 0, 'h016};
    vecs[26] = '{1, 9, 1, 0, 0, 0, 0, 0, 1, 1, 1,  1, 1, 0, 2, 1, 4, 1, 1, 0, 'h016};
    vecs[27] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1,  0, 0, 0, 1, 1, 2, 1, 0, 0, 'h006};
    vecs[28] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1,  0, 0, 0, 0, 0, 1, 1, 0, 0, 'h002};
    vecs[29] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1,  0, 0, 0, 0, 0, 0, 0, 0, 0, 'h000};
    // forwarding disabled
    vecs[30] = '{1, 3, 1, 0, 0, 0, 0, 0, 0, 0, 0,  3, 1, 0, 0, 0, 0, 0, 0, 0, 'h008};
    vecs[31] = '{1, 4, 1, 0, 3, 3, 1, 0, 0, 0, 0,  4, 1, 0, 3, 1, 0, 0, 0, 0, 'h018};
    vecs[32] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 4, 1, 3, 1, 0, 0, 'h018};
    vecs[33] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 4, 1, 0, 0, 'h010};
    vecs[34] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0, 0, 'h000};
    // same register in MEM and WB: MEM (youngest) wins on both operands
    vecs[35] = '{1, 5, 1, 0, 0, 0, 0, 0, 0, 0, 1,  5, 1, 0, 0, 0, 0, 0, 0, 0, 'h020};
    vecs[36] = '{1, 5, 1, 0, 0, 0, 0, 0, 0, 0, 1,  5, 1, 0, 5, 1, 0, 0, 0, 0, 'h020};
    vecs[37] = '{1, 6, 1, 0, 5, 5, 1, 0, 0, 0, 1,  6, 1, 0, 5, 1, 5, 1, 1, 1, 'h060};
    vecs[38] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1,  0, 0, 0, 6, 1, 5, 1, 0, 0, 'h060};
    vecs[39] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1,  0, 0, 0, 0, 0, 6, 1, 0, 0, 'h040};
    vecs[40] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1,  0, 0, 0, 0, 0, 0, 0, 0, 0, 'h000};
    // valid instruction without register write
    vecs[41] = '{1, 8, 0, 0, 0, 0, 0, 0, 0, 0, 1,  8, 0, 0, 0, 0, 0, 0, 0, 0, 'h000};
    vecs[42] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1,  0, 0, 0, 8, 0, 0, 0, 0, 0, 'h000};
    vecs[43] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1,  0, 0, 0, 0, 0, 8, 0, 0, 0, 'h000};
    vecs[44] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1,  0, 0, 0, 0, 0, 0, 0, 0, 0, 'h000};

    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    @(posedge clk);
    #1;
    z = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    check_all(-1, z);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < NV; i++) begin
      drive(vecs[i].iv, vecs[i].idst, vecs[i].iwb, vecs[i].ild, vecs[i].s1, vecs[i].s2,
            vecs[i].s2v, vecs[i].hz, vecs[i].fl, vecs[i].fz, vecs[i].fu);
      @(posedge clk);
      #1;
      check_all(i, vecs[i]);
    end

    // Asynchronous reset with three writers in flight
    for (int d = 1; d <= 3; d++) begin
      drive(1, d, 1, 0, 0, 0, 0, 0, 0, 0, 1);
      @(posedge clk);
      #1;
    end
    check("inflight_pending", 100, int'(pending), 'h00E);
    check("inflight_wb_dest", 100, int'(wb_dest), 1);
    #2;
    rst = 1'b1;
    #1;
    z = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    check_all(101, z);
    rst = 1'b0;
    drive(1, 10, 1, 0, 0, 0, 0, 0, 0, 0, 1);
    @(posedge clk);
    #1;
    check("post_rst_exe_dest",  102, int'(exe_dest),  10);
    check("post_rst_exe_wb_en", 102, int'(exe_wb_en), 1);
    check("post_rst_mem_wb_en", 102, int'(mem_wb_en), 0);
    check("post_rst_wb_en",     102, int'(wb_en),     0);
    check("post_rst_pending",   102, int'(pending),   'h400);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
